ghost_ai_ctrl: RTL
==================

// Module: ghost_ai_ctrl
// PURPOSE
//  Parametrised ghost movement controller; next generation of the fixed-start, fixed-table ghost.
//  Owns one ghost's position and heading on the 640x480 playfield.
//  Turns only when the collision checker reports a wall ahead, choosing the new heading from an LFSR.
//  Adds a frightened mode with a reversal and half speed, an eaten/respawn path, and edge clamping.
//  One instance per ghost; outputs feed the sprite renderer and the collision checker.
// PARAMETERS
//  X_W          10        width of x
//  Y_W          9         width of y
//  START_X      320       x after reset/respawn
//  START_Y      240       y after reset/respawn
//  START_DIR    2'b11     heading after reset/respawn
//  X_MAX        639       largest legal x
//  Y_MAX        479       largest legal y
//  MOVE_PERIOD  131072    clk cycles per move tick (>=2)
//  TURN_PERIOD  512       clk cycles per turn tick (>=2)
//  LFSR_SEED    16'hACE1  LFSR reset value; must be nonzero
//  FRIGHT_TICKS 600       move ticks spent frightened
// PORTS
//  clk        in   1    system clock
//  rst        in   1    asynchronous reset, active-low
//  blocked    in   1    1 = wall directly ahead in current heading (from collision checker)
//  fright_req in   1    1-cycle pulse: enter/restart frightened mode
//  eaten      in   1    1-cycle pulse: ghost eaten; honoured only while frightened
//  pac_x      in   X_W  pacman x (used only with GHOST_CHASE_EN)
//  pac_y      in   Y_W  pacman y (used only with GHOST_CHASE_EN)
//  x          out  X_W  ghost x
//  y          out  Y_W  ghost y
//  direction  out  2    heading: 00 up(y-1), 01 down(y+1), 10 left(x-1), 11 right(x+1)
//  next_dir   out  2    candidate heading for the next turn (combinational from LFSR/direction)
//  frightened out  1    1 while in FRIGHT state
// BEHAVIOUR
//  Reset: async, rst=0 -> x=START_X, y=START_Y, direction=START_DIR, state=ROAM,
//   frightened=0, LFSR=LFSR_SEED, both prescalers=0, fright counter=0.
//  Prescalers: free-running 0..PERIOD-1; tick is a 1-cycle pulse on the wrap to 0.
//   First move_tick is MOVE_PERIOD cycles after reset release.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances only on a turn tick that turns.
//  next_dir = lfsr[1:0]; if that equals direction, next_dir = lfsr[1:0]+1 (mod 4).
//  Turn: on turn_tick with effective-blocked=1 -> direction<=next_dir, LFSR steps.
//  Effective-blocked = blocked | edge, where edge is heading up at y=0, down at y=Y_MAX,
//   left at x=0, or right at x=X_MAX. Positions never wrap and never leave 0..MAX.
//  Move: on move_tick with effective-blocked=0 and move allowed -> step 1 pixel in heading.
//  Simultaneous move_tick and turn_tick: the turn wins and no step occurs that cycle.
//  States:
//   ROAM:   moves on every move_tick.
//   FRIGHT: moves on alternate move_ticks (half speed; toggle bit cleared on entry).
//   fright_req (any state) -> FRIGHT, counter=FRIGHT_TICKS, and direction reverses
//    (bit0 inverted) in the same cycle. Move/turn is suppressed that cycle.
//   FRIGHT: each move_tick decrements the counter. At 0 -> ROAM, frightened=0 next cycle.
//   eaten in FRIGHT -> x/y/direction to START values, ROAM, counter=0 on the next edge.
//   eaten in ROAM is ignored.
//   Priority when pulses coincide: eaten > fright_req > turn > move.
//  Reset mid-operation returns everything to reset values; the LFSR sequence restarts.
// CONFIGURATION
//  GHOST_CHASE_EN defined: in ROAM, the turn heading targets pacman instead of the LFSR.
//   Larger |dx| vs |dy| picks the axis; ties go to x. The sign picks the heading.
//   If that heading equals direction or is at an edge, the LFSR choice is used.
//   The LFSR still steps on every turn. FRIGHT always uses the LFSR.
//  GHOST_CHASE_EN undefined: LFSR only. pac_x/pac_y are unused.
// TESTING  (MOVE_PERIOD=4, TURN_PERIOD=2, FRIGHT_TICKS=4 unless noted)
//  1 Reset release, blocked=0 -> x increments 320,321,322 on every 4th cycle; y=240, direction=11.
//  2 Hold blocked=1 -> next turn tick sets direction=next_dir != old; x/y are frozen while blocked.
//  3 START_X=638, heading right, blocked=0 -> x stops at 639, then direction changes with no wrap.
//  4 fright_req while heading 11 -> direction=10 on the next edge and frightened=1.
//     Steps occur every 8 cycles. frightened=0 after 4 move ticks.
//  5 eaten while frightened at x=300 -> x=320, y=240, direction=11, frightened=0.
//     eaten while in ROAM -> no change.
//  6 GHOST_CHASE_EN, pac at (100,240), ghost (320,240) blocked heading 11 -> turns to 10 (left).
//     Undefined build -> LFSR heading per the seed sequence.

Source files
------------

// File: rtl/ghost_ai_ctrl.sv
// ghost_ai_ctrl: one ghost's position/heading controller with roam, frightened and eaten/respawn behaviour.
// Latency: position/heading/state update on the clk edge after a tick or pulse; next_dir is combinational.
// Backpressure: none; the collision checker's blocked input stalls motion and forces a turn on the next turn tick.
//
// Ports:
//   clk, rst (async, active-low)
//   blocked     wall directly ahead in the current heading
//   fright_req  1-cycle pulse, enter/restart frightened mode (heading reverses)
//   eaten       1-cycle pulse, honoured only while frightened: respawn at start
//   pac_x/pac_y pacman position, used only when GHOST_CHASE_EN is defined
//   x/y/direction  ghost state; next_dir = LFSR turn candidate; frightened = in FRIGHT
//
// Build option: define GHOST_CHASE_EN to make ROAM turns steer toward pacman.
module ghost_ai_ctrl #(
  parameter int          X_W          = 10,
  parameter int          Y_W          = 9,
  parameter int unsigned START_X      = 320,
  parameter int unsigned START_Y      = 240,
  parameter logic [1:0]  START_DIR    = 2'b11,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned MOVE_PERIOD  = 131072,
  parameter int unsigned TURN_PERIOD  = 512,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned FRIGHT_TICKS = 600
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           blocked,
  input  logic           fright_req,
  input  logic           eaten,
  input  logic [X_W-1:0] pac_x,
  input  logic [Y_W-1:0] pac_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     direction,
  output logic [1:0]     next_dir,
  output logic           frightened
);

  localparam int MV_W = $clog2(MOVE_PERIOD);
  localparam int TN_W = $clog2(TURN_PERIOD);
  localparam int FC_W = (FRIGHT_TICKS < 1) ? 1 : $clog2(FRIGHT_TICKS + 1);

  localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_PERIOD - 1);
  localparam logic [TN_W-1:0] TN_LAST = TN_W'(TURN_PERIOD - 1);
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FRIGHT_TICKS);
  localparam logic [X_W-1:0]  X_START = X_W'(START_X);
  localparam logic [Y_W-1:0]  Y_START = Y_W'(START_Y);
  localparam logic [X_W-1:0]  X_LIM   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]  Y_LIM   = Y_W'(Y_MAX);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic {ROAM, FRIGHT} state_t;

  state_t          state, state_nxt;
  logic [MV_W-1:0] move_cnt;
  logic [TN_W-1:0] turn_cnt;
  logic [FC_W-1:0] fcnt, fcnt_nxt;
  logic            half, half_nxt;
  logic [15:0]     lfsr, lfsr_nxt;
  logic [X_W-1:0]  x_nxt;
  logic [Y_W-1:0]  y_nxt;
  logic [1:0]      dir_nxt;
  logic            move_tick, turn_tick;
  logic            eff_blocked;
  logic [1:0]      turn_dir;
  logic [15:0]     lfsr_step;

  // True when heading d from (px,py) would leave the playfield.
  function automatic logic hits_edge(input logic [1:0] d, input logic [X_W-1:0] px,
                                     input logic [Y_W-1:0] py);
    case (d)
      DIR_UP:   hits_edge = (py == '0);
      DIR_DOWN: hits_edge = (py == Y_LIM);
      DIR_LEFT: hits_edge = (px == '0);
      default:  hits_edge = (px == X_LIM);
    endcase
  endfunction

  assign move_tick   = (move_cnt == MV_LAST);
  assign turn_tick   = (turn_cnt == TN_LAST);
  assign eff_blocked = blocked | hits_edge(direction, x, y);
  assign frightened  = (state == FRIGHT);

  // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in shift-right form).
  assign lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  // Never offer the current heading as a turn candidate.
  assign next_dir = (lfsr[1:0] == direction) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

`ifdef GHOST_CHASE_EN
  localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

  logic signed [D_W-1:0] dx, dy;
  logic [D_W-1:0]        adx, ady;
  logic [1:0]            chase_dir;

  always_comb begin
    dx  = $signed(D_W'(pac_x)) - $signed(D_W'(x));
    dy  = $signed(D_W'(pac_y)) - $signed(D_W'(y));
    adx = dx[D_W-1] ? D_W'(-dx) : D_W'(dx);
    ady = dy[D_W-1] ? D_W'(-dy) : D_W'(dy);
    // Ties go to the x axis.
    if (adx >= ady) begin
      chase_dir = dx[D_W-1] ? DIR_LEFT : DIR_RIGHT;
    end else begin
      chase_dir = dy[D_W-1] ? DIR_UP : DIR_DOWN;
    end
  end

  // Chase only in ROAM, and fall back to the random pick if the chase
  // heading is no turn at all or points straight off the playfield.
  assign turn_dir = (state == ROAM && chase_dir != direction && !hits_edge(chase_dir, x, y))
                    ? chase_dir : next_dir;
`else
  logic unused_pac;
  assign unused_pac = ^{pac_x, pac_y};
  assign turn_dir   = next_dir;
`endif

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    dir_nxt   = direction;
    lfsr_nxt  = lfsr;
    fcnt_nxt  = fcnt;
    half_nxt  = half;

    if (eaten && state == FRIGHT) begin
      state_nxt = ROAM;
      x_nxt     = X_START;
      y_nxt     = Y_START;
      dir_nxt   = START_DIR;
      fcnt_nxt  = '0;
      half_nxt  = 1'b0;
    end else if (fright_req) begin
      // Reversal is a bit0 flip: up<->down, left<->right.
      state_nxt = FRIGHT;
      fcnt_nxt  = FC_INIT;
      dir_nxt   = {direction[1], ~direction[0]};
      half_nxt  = 1'b0;
    end else begin
      // Turning needs a wall ahead and stepping needs none, so a single
      // if/else gives the turn precedence on coincident ticks.
      if (turn_tick && eff_blocked) begin
        dir_nxt  = turn_dir;
        lfsr_nxt = lfsr_step;
      end else if (move_tick && !eff_blocked && (state == ROAM || half)) begin
        case (direction)
          DIR_UP:   y_nxt = y - Y_W'(1);
          DIR_DOWN: y_nxt = y + Y_W'(1);
          DIR_LEFT: x_nxt = x - X_W'(1);
          default:  x_nxt = x + X_W'(1);
        endcase
      end
      if (state == FRIGHT) begin
        if (move_tick) begin
          half_nxt = ~half;
          if (fcnt != '0) fcnt_nxt = fcnt - FC_W'(1);
        end
        // Counter already exhausted: leave FRIGHT on this edge.
        if (fcnt == '0) state_nxt = ROAM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ROAM;
      x         <= X_START;
      y         <= Y_START;
      direction <= START_DIR;
      lfsr      <= LFSR_SEED;
      fcnt      <= '0;
      half      <= 1'b0;
      move_cnt  <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      direction <= dir_nxt;
      lfsr      <= lfsr_nxt;
      fcnt      <= fcnt_nxt;
      half      <= half_nxt;
      move_cnt  <= move_tick ? '0 : move_cnt + MV_W'(1);
      turn_cnt  <= turn_tick ? '0 : turn_cnt + TN_W'(1);
    end
  end

endmodule
